// File: rtl/simple_ctrl_pkg.sv
// Shared encodings for the SIMPLE multi-cycle controller: opcode fields,
// branch condition codes, FSM state codes and the one-hot phase values.
package simple_ctrl_pkg;

    // op1 major opcode
    localparam logic [1:0] OP1_LD  = 2'b00;
    localparam logic [1:0] OP1_ST  = 2'b01;
    localparam logic [1:0] OP1_BR  = 2'b10;
    localparam logic [1:0] OP1_ALU = 2'b11;

    // op2 sub-opcode within the op1=10 group
    localparam logic [2:0] OP2_LI    = 3'b000;
    localparam logic [2:0] OP2_B     = 3'b100;
    localparam logic [2:0] OP2_BCOND = 3'b111;

    // condition codes for the conditional branch
    localparam logic [2:0] COND_BE  = 3'b000;
    localparam logic [2:0] COND_BLT = 3'b001;
    localparam logic [2:0] COND_BLE = 3'b010;
    localparam logic [2:0] COND_BNE = 3'b011;

    // op3 ALU function codes that need special handling
    localparam logic [3:0] OP3_CMP = 4'b0101;
    localparam logic [3:0] OP3_IN  = 4'b1100;
    localparam logic [3:0] OP3_OUT = 4'b1101;
    localparam logic [3:0] OP3_HLT = 4'b1111;

    // FSM state codes
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_P1   = 3'd1;
    localparam logic [2:0] ST_P2   = 3'd2;
    localparam logic [2:0] ST_P3   = 3'd3;
    localparam logic [2:0] ST_P4   = 3'd4;
    localparam logic [2:0] ST_P5   = 3'd5;
    localparam logic [2:0] ST_HALT = 3'd6;

    // one-hot phase indication, zero outside P1..P5
    localparam logic [4:0] PH_NONE = 5'b00000;
    localparam logic [4:0] PH_P1   = 5'b00001;
    localparam logic [4:0] PH_P2   = 5'b00010;
    localparam logic [4:0] PH_P3   = 5'b00100;
    localparam logic [4:0] PH_P4   = 5'b01000;
    localparam logic [4:0] PH_P5   = 5'b10000;

    // Map an FSM state onto its one-hot phase code.
    function automatic logic [4:0] phase_of(input logic [2:0] st);
        case (st)
            ST_P1:   return PH_P1;
            ST_P2:   return PH_P2;
            ST_P3:   return PH_P3;
            ST_P4:   return PH_P4;
            ST_P5:   return PH_P5;
            default: return PH_NONE;
        endcase
    endfunction

endpackage

// File: rtl/simple_ctrl_decode.sv
// Purely combinational instruction decoder for the SIMPLE core. Produces the
// unqualified control levels and the branch-taken decision; the controller
// top gates them with the current phase.
module simple_ctrl_decode
    import simple_ctrl_pkg::*;
#(
    parameter int INSTR_W = 16
) (
    input  logic [INSTR_W-1:0] instr,
    input  logic [3:0]         flags,
    output logic               is_ld,
    output logic               is_st,
    output logic               mem_to_reg,
    output logic               reg_dst,
    output logic               alu_src,
    output logic               reg_write,
    output logic               out_op,
    output logic               halt_op,
    output logic               taken
);

    logic [1:0] op1_s;
    logic [2:0] op2_s;
    logic [2:0] cond_s;
    logic [3:0] op3_s;
    logic       nop_s;
    logic       is_alu_s;
    logic       is_li_s;
    logic       is_in_s;
    logic       flag_s_s;
    logic       flag_z_s;
    logic       flag_v_s;
    logic       cond_ok_s;
    logic       flag_c_unused_s;

    assign op1_s  = instr[INSTR_W-1 -: 2];
    assign op2_s  = instr[INSTR_W-3 -: 3];
    assign cond_s = instr[INSTR_W-6 -: 3];
    assign op3_s  = instr[7:4];

    // The all-zero word shares the LD encoding but must behave as a NOP.
    assign nop_s    = (instr == {INSTR_W{1'b0}});
    assign is_alu_s = (op1_s == OP1_ALU);
    assign is_li_s  = (op1_s == OP1_BR) && (op2_s == OP2_LI);
    assign is_in_s  = is_alu_s && (op3_s == OP3_IN);

    // flags = {S,Z,C,V}; carry plays no part in branch conditions
    assign flag_s_s        = flags[3];
    assign flag_z_s        = flags[2];
    assign flag_c_unused_s = flags[1];
    assign flag_v_s        = flags[0];

    assign is_ld      = (op1_s == OP1_LD) && !nop_s;
    assign is_st      = (op1_s == OP1_ST);
    assign mem_to_reg = is_ld || is_li_s || is_in_s;
    assign reg_dst    = (op1_s != OP1_LD);
    assign alu_src    = is_alu_s && (op3_s[3:2] == 2'b10);
    assign out_op     = is_alu_s && (op3_s == OP3_OUT);
    assign halt_op    = is_alu_s && (op3_s == OP3_HLT);
    assign reg_write  = !nop_s && (is_ld || is_li_s ||
                        (is_alu_s && (op3_s != OP3_CMP) && (op3_s != OP3_OUT) && (op3_s != OP3_HLT)));

    // Evaluate the conditional-branch predicate from the flag register.
    always_comb begin
        cond_ok_s = 1'b0;
        case (cond_s)
            COND_BE:  cond_ok_s = flag_z_s;
            COND_BLT: cond_ok_s = flag_s_s ^ flag_v_s;
            COND_BLE: cond_ok_s = flag_z_s | (flag_s_s ^ flag_v_s);
            COND_BNE: cond_ok_s = !flag_z_s;
            default:  cond_ok_s = 1'b0;
        endcase
    end

    assign taken = (op1_s == OP1_BR) &&
                   ((op2_s == OP2_B) || ((op2_s == OP2_BCOND) && cond_ok_s));

endmodule

// File: rtl/multicycle_controller.sv
// Five-phase multi-cycle sequencer for the SIMPLE core: run/halt FSM, exec
// rising-edge detector, phase-qualified control strobes and a retired
// instruction counter.
// Optional build macro MCTRL_PHASE_SKIP_EN: when defined, instructions with no
// data-memory access skip P4 (P3 goes straight to P5).
module multicycle_controller
    import simple_ctrl_pkg::*;
#(
    parameter int INSTR_W = 16,
    parameter int CNT_W   = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               exec,
    input  logic [INSTR_W-1:0] instr,
    input  logic [3:0]         flags,
    output logic               ir_load,
    output logic               pc_inc,
    output logic               mem_read,
    output logic               mem_write,
    output logic               RegWrite,
    output logic               MemtoReg,
    output logic               RegDst,
    output logic               ALUSrc,
    output logic               PCSrc,
    output logic               out_en,
    output logic               halted,
    output logic [4:0]         phase,
    output logic [CNT_W-1:0]   retired
);

    logic [2:0]       state_r;
    logic [2:0]       state_nxt_s;
    logic             exec_q_r;
    logic             exec_rise_s;
    logic [CNT_W-1:0] retired_r;
    logic [4:0]       phase_s;
    logic             level_en_s;

    logic dec_is_ld_s;
    logic dec_is_st_s;
    logic dec_mem_to_reg_s;
    logic dec_reg_dst_s;
    logic dec_alu_src_s;
    logic dec_reg_write_s;
    logic dec_out_op_s;
    logic dec_halt_op_s;
    logic dec_taken_s;

    simple_ctrl_decode #(
        .INSTR_W (INSTR_W)
    ) u_decode (
        .instr      (instr),
        .flags      (flags),
        .is_ld      (dec_is_ld_s),
        .is_st      (dec_is_st_s),
        .mem_to_reg (dec_mem_to_reg_s),
        .reg_dst    (dec_reg_dst_s),
        .alu_src    (dec_alu_src_s),
        .reg_write  (dec_reg_write_s),
        .out_op     (dec_out_op_s),
        .halt_op    (dec_halt_op_s),
        .taken      (dec_taken_s)
    );

    // Only a fresh 0->1 on exec may leave HALT; a level held high does not.
    assign exec_rise_s = exec && !exec_q_r;

    // Next-state logic; once P1 is entered the instruction always runs to P5.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (exec) begin
                    state_nxt_s = ST_P1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_P1: state_nxt_s = ST_P2;
            ST_P2: state_nxt_s = ST_P3;
            ST_P3: begin
`ifdef MCTRL_PHASE_SKIP_EN
                if (dec_is_ld_s || dec_is_st_s) begin
                    state_nxt_s = ST_P4;
                end else begin
                    state_nxt_s = ST_P5;
                end
`else
                state_nxt_s = ST_P4;
`endif
            end
            ST_P4: state_nxt_s = ST_P5;
            ST_P5: begin
                if (dec_halt_op_s) begin
                    state_nxt_s = ST_HALT;
                end else if (exec) begin
                    state_nxt_s = ST_P1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_HALT: begin
                if (exec_rise_s) begin
                    state_nxt_s = ST_P1;
                end else begin
                    state_nxt_s = ST_HALT;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, exec history and retired-instruction count (wraps naturally).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            exec_q_r  <= 1'b0;
            retired_r <= {CNT_W{1'b0}};
        end else begin
            state_r  <= state_nxt_s;
            exec_q_r <= exec;
            if (state_r == ST_P5) begin
                retired_r <= retired_r + CNT_W'(1);
            end else begin
                retired_r <= retired_r;
            end
        end
    end

    // All outputs derive from registered state, so reset clears them at once.
    assign phase_s    = phase_of(state_r);
    assign level_en_s = |phase_s[4:1];

    assign phase     = phase_s;
    assign halted    = (state_r == ST_HALT);
    assign retired   = retired_r;
    assign ir_load   = phase_s[0];
    assign pc_inc    = phase_s[0];
    assign mem_read  = phase_s[3] && dec_is_ld_s;
    assign mem_write = phase_s[3] && dec_is_st_s;
    assign RegWrite  = phase_s[4] && dec_reg_write_s;
    assign PCSrc     = phase_s[4] && dec_taken_s;
    assign out_en    = phase_s[4] && dec_out_op_s;
    assign MemtoReg  = level_en_s && dec_mem_to_reg_s;
    assign RegDst    = level_en_s && dec_reg_dst_s;
    assign ALUSrc    = level_en_s && dec_alu_src_s;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: stimulus pushes expected
// per-phase outputs, a negedge monitor pops and compares them.
module tb_multicycle_controller;

    typedef struct packed {
        logic [15:0] instr;
        logic [3:0]  flags;
        logic [7:0]  ctl;   // {m2r, rdst, asrc, rw, mrd, mwr, pcs, oen}
    } vec_t;

    typedef struct packed {
        logic [4:0]  ph;
        logic [10:0] st;    // {ir_load,pc_inc,mem_read,mem_write,RegWrite,MemtoReg,RegDst,ALUSrc,PCSrc,out_en,halted}
        logic [31:0] ret;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        exec;
    logic [15:0] instr;
    logic [3:0]  flags;
    logic        ir_load, pc_inc, mem_read, mem_write, RegWrite, MemtoReg;
    logic        RegDst, ALUSrc, PCSrc, out_en, halted;
    logic [4:0]  phase;
    logic [31:0] retired;

    int          n_tests = 0;
    int          n_fail  = 0;
    exp_t        sb[$];
    exp_t        mon_e;
    exp_t        mon_a;
    logic [31:0] exp_retired;
    vec_t        vecs[15];
    vec_t        v_add;
    vec_t        v_hlt;

    multicycle_controller #(.INSTR_W(16), .CNT_W(32)) dut (
        .clock(clk), .reset(reset), .exec(exec), .instr(instr), .flags(flags),
        .ir_load(ir_load), .pc_inc(pc_inc), .mem_read(mem_read), .mem_write(mem_write),
        .RegWrite(RegWrite), .MemtoReg(MemtoReg), .RegDst(RegDst), .ALUSrc(ALUSrc),
        .PCSrc(PCSrc), .out_en(out_en), .halted(halted), .phase(phase), .retired(retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [10:0] act_st();
        return {ir_load, pc_inc, mem_read, mem_write, RegWrite, MemtoReg,
                RegDst, ALUSrc, PCSrc, out_en, halted};
    endfunction

    function automatic exp_t mk_entry(input vec_t v, input int k, input logic [31:0] r);
        exp_t e;
        e.ph  = 5'b00001 << k;
        e.ret = r;
        e.st  = 11'b0;
        if (k == 0) begin
            e.st[10] = 1'b1;
            e.st[9]  = 1'b1;
        end else begin
            e.st[5] = v.ctl[7];
            e.st[4] = v.ctl[6];
            e.st[3] = v.ctl[5];
            if (k == 3) begin
                e.st[8] = v.ctl[3];
                e.st[7] = v.ctl[2];
            end
            if (k == 4) begin
                e.st[6] = v.ctl[4];
                e.st[2] = v.ctl[1];
                e.st[1] = v.ctl[0];
            end
        end
        return e;
    endfunction

    function automatic exp_t halt_entry(input logic [31:0] r);
        exp_t e;
        e.ph  = 5'b00000;
        e.st  = 11'b00000000001;
        e.ret = r;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    // Monitor: every cycle the DUT shows a phase or HALT, pop and compare.
    always @(negedge clk) begin
        if (!reset && (phase != 5'd0 || halted)) begin
            n_tests++;
            mon_a.ph  = phase;
            mon_a.st  = act_st();
            mon_a.ret = retired;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output: got ph=%b st=%b ret=%0d, expected no activity",
                         mon_a.ph, mon_a.st, mon_a.ret);
            end else begin
                mon_e = sb.pop_front();
                if (mon_a !== mon_e) begin
                    n_fail++;
                    $display("FAIL phase_outputs @%0t: got ph=%b st=%b ret=%0d, expected ph=%b st=%b ret=%0d",
                             $time, mon_a.ph, mon_a.st, mon_a.ret, mon_e.ph, mon_e.st, mon_e.ret);
                end
            end
        end
    end

    // Caller guarantees the DUT enters P1 on the next rising edge.
    task automatic run_instr(input vec_t v, input bit keep, input bit drop_p2);
        int ks[5];
        int n;
        ks = '{0, 1, 2, 3, 4};
        n  = 5;
`ifdef MCTRL_PHASE_SKIP_EN
        if (!(v.ctl[3] || v.ctl[2])) begin
            ks = '{0, 1, 2, 4, 0};
            n  = 4;
        end
`endif
        @(posedge clk); #1;
        instr = v.instr;
        flags = v.flags;
        for (int i = 0; i < n; i++) sb.push_back(mk_entry(v, ks[i], exp_retired));
        for (int i = 1; i < n; i++) begin
            @(posedge clk); #1;
            if (drop_p2 && i == 1) exec = 1'b0;
        end
        exec = keep;
        exp_retired = exp_retired + 32'd1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1);
    end

    initial begin
        v_add    = '{16'hC000, 4'b0000, 8'b01010000};
        v_hlt    = '{16'hC0F0, 4'b0000, 8'b01000000};
        vecs[0]  = v_add;                                  // ADD
        vecs[1]  = '{16'h0123, 4'b0000, 8'b10011000};      // LD
        vecs[2]  = '{16'h4123, 4'b0000, 8'b01000100};      // ST
        vecs[3]  = '{16'hB805, 4'b0100, 8'b01000010};      // BE, Z=1 taken
        vecs[4]  = '{16'hB805, 4'b0000, 8'b01000000};      // BE, Z=0 not taken
        vecs[5]  = '{16'hA003, 4'b0000, 8'b01000010};      // B always
        vecs[6]  = '{16'hB900, 4'b1000, 8'b01000010};      // BLT, S^V=1
        vecs[7]  = '{16'hBB00, 4'b0100, 8'b01000000};      // BNE, Z=1 not taken
        vecs[8]  = '{16'hBA00, 4'b0001, 8'b01000010};      // BLE, V=1 taken
        vecs[9]  = '{16'h8042, 4'b0000, 8'b11010000};      // LI
        vecs[10] = '{16'hC050, 4'b0000, 8'b01000000};      // CMP
        vecs[11] = '{16'hC0D0, 4'b0000, 8'b01000001};      // OUT
        vecs[12] = '{16'hC183, 4'b0000, 8'b01110000};      // SLL immediate
        vecs[13] = '{16'hC0C0, 4'b0000, 8'b11010000};      // IN
        vecs[14] = '{16'h0000, 4'b0000, 8'b00000000};      // NOP

        reset = 1'b1; exec = 1'b0; instr = 16'h0000; flags = 4'b0000;
        exp_retired = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_phase", 64'(phase), 64'd0);
        chk("reset_strobes", 64'(act_st()), 64'd0);
        chk("reset_retired", 64'(retired), 64'd0);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        chk("idle_no_exec", 64'(phase), 64'd0);

        // back-to-back directed instructions with exec held high
        exec = 1'b1;
        for (int i = 0; i < 15; i++) run_instr(vecs[i], 1'b1, 1'b0);

        // exec dropped during P2: instruction completes, then IDLE
        run_instr(v_add, 1'b0, 1'b1);
        @(posedge clk); #1;
        chk("drop_exec_idle", 64'(phase), 64'd0);
        chk("drop_exec_retired", 64'(retired), 64'(exp_retired));

        // HLT with exec held: stays halted until a fresh rising edge
        exec = 1'b1;
        run_instr(v_hlt, 1'b1, 1'b0);
        repeat (3) sb.push_back(halt_entry(exp_retired));
        repeat (3) begin @(posedge clk); #1; end
        chk("halt_held_exec", 64'(halted), 64'd1);
        exec = 1'b0;
        sb.push_back(halt_entry(exp_retired));
        @(posedge clk); #1;
        chk("halt_exec_low", 64'(halted), 64'd1);
        exec = 1'b1;
        run_instr(v_add, 1'b1, 1'b0);

        // async reset while in P3
        @(posedge clk); #1;
        instr = v_add.instr; flags = v_add.flags;
        for (int k = 0; k < 3; k++) sb.push_back(mk_entry(v_add, k, exp_retired));
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk); #2;
        reset = 1'b1;
        #1;
        chk("midp3_reset_phase", 64'(phase), 64'd0);
        chk("midp3_reset_strobes", 64'(act_st()), 64'd0);
        chk("midp3_reset_retired", 64'(retired), 64'd0);
        exec = 1'b0;
        exp_retired = 32'd0;
        @(posedge clk); #1;
        chk("reset_hold_phase", 64'(phase), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        exec  = 1'b1;
        run_instr(v_add, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("post_reset_idle", 64'(phase), 64'd0);
        chk("post_reset_retired", 64'(retired), 64'(exp_retired));

        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
